// File: rtl/j1_pkg.sv
// Shared J1 definitions: boot loader state encoding, default image magic
// byte and program RAM depth.
package j1_pkg;

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

  localparam logic [7:0]  J1_MAGIC     = 8'hA5;
  localparam int unsigned J1_RAM_WORDS = 8192;

  // An image word count is usable when it is non-zero and fits the RAM.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != '0) && (n <= 16'(J1_RAM_WORDS));
  endfunction

endpackage

// File: rtl/j1_loader.sv
// J1 boot loader: receives a byte-stream image (magic, 16-bit LE word
// count, LE data words, XOR checksum), writes it into program RAM and
// releases the CPU from reset once the checksum matches.
module j1_loader
  import j1_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000,
  parameter logic [7:0]  MAGIC   = J1_MAGIC
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        boot_req_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [12:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  output logic        mem_we_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  loader_state_t     state_q;
  logic [7:0]        lo_q;
  logic [7:0]        csum_q;
  logic [12:0]       idx_q;
  logic [12:0]       last_q;
  logic [IDLE_W-1:0] idle_q;

  logic              xfer;
  logic              loading;
  logic [15:0]       len_w;
  logic [IDLE_W-1:0] idle_inc;

  assign xfer     = rx_valid_i & rx_ready_o;
  assign len_w    = {rx_data_i, lo_q};
  assign idle_inc = idle_q + IDLE_W'(1);

  // Status outputs decoded straight from the state register.
  always_comb begin
    loading    = 1'b0;
    rx_ready_o = 1'b1;
    cpu_rst_o  = 1'b1;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK: loading = 1'b1;
      RUN: begin
        rx_ready_o = 1'b0;
        cpu_rst_o  = 1'b0;
        done_o     = 1'b1;
      end
      ERROR: begin
        rx_ready_o = 1'b0;
        err_o      = 1'b1;
      end
      default: ;
    endcase
    busy_o = loading;
  end

  // Loader FSM with idle watchdog, checksum and RAM write port.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q    <= WAIT_MAGIC;
      lo_q       <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      idle_q     <= '0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      mem_we_o <= 1'b0;
      if (boot_req_i) begin
        // Restart takes priority; any byte offered this cycle is dropped.
        state_q <= WAIT_MAGIC;
        lo_q    <= '0;
        csum_q  <= '0;
        idx_q   <= '0;
        last_q  <= '0;
        idle_q  <= '0;
      end else begin
        // Entry to LEN_LO is always by a transfer, which clears the counter.
        if (xfer) begin
          idle_q <= '0;
        end else if (loading) begin
          idle_q <= idle_inc;
          if (idle_inc == IDLE_W'(TIMEOUT)) state_q <= ERROR;
        end

        if (xfer) begin
          case (state_q)
            WAIT_MAGIC: if (rx_data_i == MAGIC) state_q <= LEN_LO;
            LEN_LO: begin
              lo_q    <= rx_data_i;
              state_q <= LEN_HI;
            end
            LEN_HI: begin
              if (len_ok(len_w)) begin
                last_q  <= 13'(len_w - 16'd1);
                idx_q   <= '0;
                csum_q  <= '0;
                state_q <= DATA_LO;
              end else begin
                state_q <= ERROR;
              end
            end
            DATA_LO: begin
              lo_q    <= rx_data_i;
              csum_q  <= csum_q ^ rx_data_i;
              state_q <= DATA_HI;
            end
            DATA_HI: begin
              csum_q     <= csum_q ^ rx_data_i;
              mem_we_o   <= 1'b1;
              mem_addr_o <= idx_q;
              mem_data_o <= {rx_data_i, lo_q};
              idx_q      <= idx_q + 13'd1;
              state_q    <= (idx_q == last_q) ? CHECK : DATA_LO;
            end
            CHECK: state_q <= (rx_data_i == csum_q) ? RUN : ERROR;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_j1_loader.sv
// Bench for j1_loader: table of whole images with expected RAM writes
// queued on a scoreboard, plus hand sequences for timeout, restart and
// asynchronous reset corners.
module tb_j1_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        boot_req = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [12:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [28:0] exp_q[$];

  always #5 clk = ~clk;

  j1_loader #(.TIMEOUT(16), .MAGIC(8'hA5)) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .boot_req_i  (boot_req),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_we_o    (mem_we),
    .cpu_rst_o   (cpu_rst),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  typedef struct {
    string       name;
    int unsigned nb;
    logic [95:0] b;
    int unsigned nw;
    logic [63:0] w;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [28:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                   mem_addr, mem_data, e[28:16], e[15:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic boot();
    rx_valid = 1'b0;
    boot_req = 1'b1;
    @(posedge clk);
    #1 boot_req = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{name:"two_words",   nb:8,  b:96'hA5_02_00_34_12_78_56_08_00_00_00_00,
                nw:2, w:64'h1234_5678_0000_0000, done:1'b1, err:1'b0};
    vecs[1] = '{name:"bad_csum",    nb:8,  b:96'hA5_02_00_34_12_78_56_00_00_00_00_00,
                nw:2, w:64'h1234_5678_0000_0000, done:1'b0, err:1'b1};
    vecs[2] = '{name:"len_zero",    nb:5,  b:96'h00_FF_A5_00_00_00_00_00_00_00_00_00,
                nw:0, w:64'h0, done:1'b0, err:1'b1};
    vecs[3] = '{name:"one_word",    nb:6,  b:96'hA5_01_00_CD_AB_66_00_00_00_00_00_00,
                nw:1, w:64'hABCD_0000_0000_0000, done:1'b1, err:1'b0};
    vecs[4] = '{name:"len_8193",    nb:3,  b:96'hA5_01_20_00_00_00_00_00_00_00_00_00,
                nw:0, w:64'h0, done:1'b0, err:1'b1};
    vecs[5] = '{name:"three_words", nb:11, b:96'h5A_A5_03_00_01_00_02_00_04_00_07_00,
                nw:3, w:64'h0001_0002_0004_0000, done:1'b1, err:1'b0};

    // Reset values, sampled while reset is held.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_flags",    32'({busy, done, err}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of whole images.
    for (int v = 0; v < 6; v++) begin
      boot();
      for (int k = 0; k < int'(vecs[v].nw); k++)
        exp_q.push_back({13'(k), vecs[v].w[63-16*k -: 16]});
      for (int i = 0; i < int'(vecs[v].nb); i++)
        send_byte(vecs[v].b[95-8*i -: 8]);
      @(negedge clk);
      chk({vecs[v].name, "_done"},     32'(done),     32'(vecs[v].done));
      chk({vecs[v].name, "_err"},      32'(err),      32'(vecs[v].err));
      chk({vecs[v].name, "_cpu_rst"},  32'(cpu_rst),  32'(!vecs[v].done));
      chk({vecs[v].name, "_rx_ready"}, 32'(rx_ready), 32'd0);
      chk({vecs[v].name, "_busy"},     32'(busy),     32'd0);
      chk({vecs[v].name, "_pending"},  32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
    end

    // Restart from RUN: CPU held again on the very next cycle.
    boot();
    chk("reboot_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("reboot_rx_ready", 32'(rx_ready), 32'd1);
    chk("reboot_done",     32'(done),     32'd0);

    // No watchdog while hunting for the magic byte.
    repeat (40) @(posedge clk);
    #1;
    chk("wait_magic_no_timeout", 32'(err), 32'd0);

    // Idle abort exactly TIMEOUT cycles after the last accepted byte.
    send_byte(8'hA5);
    send_byte(8'h01);
    cnt = 0;
    while (err !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("timeout_cycles", 32'(cnt), 32'd16);

    // Largest legal word count is accepted.
    boot();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h20);
    @(negedge clk);
    chk("len_8192_busy", 32'(busy), 32'd1);
    chk("len_8192_err",  32'(err),  32'd0);
    @(posedge clk);
    #1;

    // Restart request beats a byte offered in the same cycle.
    boot();
    send_byte(8'hA5);
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    boot_req = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    boot_req = 1'b0;
    chk("boot_wins_busy", 32'(busy), 32'd0);
    exp_q.push_back({13'd0, 16'hABCD});
    for (int i = 0; i < 6; i++) send_byte(vecs[3].b[95-8*i -: 8]);
    @(negedge clk);
    chk("after_boot_done", 32'(done), 32'd1);
    chk("after_boot_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset with the high byte of a word on the bus.
    boot();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    rx_data  = 8'h22;
    rx_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("async_busy",     32'(busy),     32'd0);
    chk("async_rx_ready", 32'(rx_ready), 32'd1);
    chk("async_mem_data", 32'(mem_data), 32'd0);
    chk("async_mem_we",   32'(mem_we),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_mem_we", 32'(mem_we), 32'd0);
    chk("post_reset_addr",   32'(mem_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
